// File: rtl/cmsdk_ahb_arb_pkg.sv
// Shared encodings and helpers for the N-port AHB output-stage arbiter.
// Holds the AHB transfer/burst encodings, the arbitration mode selectors
// and the beat-count reload lookup used by the burst tracker.
package cmsdk_ahb_arb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Arbitration modes
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of the remaining-beat counter (enough for a 16-beat burst)
    localparam int BEAT_W = 4;

    // Number of beats still to come after the NONSEQ of a fixed-length
    // burst. Undefined-length (INCR) and SINGLE return 0: INCR is held
    // open by its HBURST value instead of by the counter.
    function automatic logic [BEAT_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [BEAT_W-1:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/cmsdk_ahb_arb_rr_pick.sv
// Rotating priority encoder. Returns the first set bit of 'eligible'
// searching from ptr+1 upwards, wrapping modulo NUM_PORTS (so any port
// count, power of two or not, is handled). With ptr tied to NUM_PORTS-1
// the search starts at index 0, which gives plain fixed priority.
module cmsdk_ahb_arb_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    idx,
    output logic                 valid
);

    // Scan offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        int j;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            j = (int'(ptr) + k) % NUM_PORTS;
            if (eligible[j]) begin
                idx   = PORT_W'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmsdk_ahb_out_arb_np.sv
// Output-stage arbiter for one slave port of the AHB bus matrix, with N
// input stages. Picks which input stage owns the shared slave, either by
// fixed priority (port 0 highest) or round-robin. A locked sequence or a
// defined-length burst in progress is never interrupted; undefined-length
// INCR bursts are held until the owner stops issuing SEQ/BUSY.
//
// Handshake: req_port[i] is a level request from input stage i and stays
// asserted until that stage is served; HREADYM acts as the ready/advance
// strobe -- every piece of arbiter state moves only on a rising HCLK edge
// where HREADYM is 1, so wait states never alter the grant. A request seen
// on such an edge shows up on addr_in_port in the following cycle.
module cmsdk_ahb_out_arb_np
    import cmsdk_ahb_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int ARB_MODE  = ARB_FIXED
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    // Pointer value that makes the rotating search start at port 0
    localparam logic [PORT_W-1:0] PTR_LAST = PORT_W'(NUM_PORTS - 1);

    logic [PORT_W-1:0]    rr_ptr;
    logic [BEAT_W-1:0]    beat_cnt;

    logic                 active;
    logic [NUM_PORTS-1:0] cur_onehot;
    logic [NUM_PORTS-1:0] eligible;
    logic                 hold;
    logic [BEAT_W-1:0]    beat_cnt_nxt;

    logic [PORT_W-1:0]    pick_ptr;
    logic [PORT_W-1:0]    pick_idx;
    logic                 pick_valid;

    logic [PORT_W-1:0]    addr_nxt;
    logic                 no_port_nxt;
    logic [PORT_W-1:0]    rr_ptr_nxt;

    // The current owner stays a candidate while it is still talking to the
    // slave, even if its own request line has dropped.
    always_comb begin
        active = HSELM & (HTRANSM != HTRANS_IDLE);
        for (int i = 0; i < NUM_PORTS; i++) begin
            cur_onehot[i] = (int'(addr_in_port) == i);
        end
        eligible = req_port | (cur_onehot & {NUM_PORTS{active}});
    end

    // Remaining-beat tracking; a NONSEQ or IDLE arriving before the count
    // expires is an early-terminated burst, so the count restarts/clears.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        case (HTRANSM)
            HTRANS_NONSEQ: beat_cnt_nxt = HSELM ? burst_beats(HBURSTM) : '0;
            HTRANS_SEQ:    beat_cnt_nxt = (beat_cnt == '0) ? '0 : beat_cnt - 1'b1;
            HTRANS_IDLE:   beat_cnt_nxt = '0;
            default:       beat_cnt_nxt = beat_cnt;
        endcase
    end

    // Ownership is frozen for locked transfers and for SEQ/BUSY beats that
    // still belong to a fixed-length burst or to an undefined-length INCR.
    always_comb begin
        hold = HMASTLOCKM
             | (((HTRANSM == HTRANS_BUSY) | (HTRANSM == HTRANS_SEQ))
                & ((beat_cnt != '0) | (HBURSTM == HBURST_INCR)));
    end

    // Fixed mode reuses the rotating encoder with the search anchored at 0.
    always_comb begin
        pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : PTR_LAST;
    end

    cmsdk_ahb_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    // Next grant: hold wins, then a new pick, then keep the current port
    // selected (idling) while the slave is addressed, else release.
    always_comb begin
        addr_nxt    = addr_in_port;
        no_port_nxt = no_port;
        rr_ptr_nxt  = rr_ptr;
        if (hold) begin
            addr_nxt    = addr_in_port;
            no_port_nxt = no_port;
        end else if (pick_valid) begin
            addr_nxt    = pick_idx;
            no_port_nxt = 1'b0;
            // Only a real grant moves the pointer: a change of owner, or
            // the owner re-winning with its request still raised.
            if ((ARB_MODE == ARB_RR) &&
                ((pick_idx != addr_in_port) || req_port[pick_idx])) begin
                rr_ptr_nxt = pick_idx;
            end
        end else if (HSELM) begin
            no_port_nxt = 1'b0;
        end else begin
            no_port_nxt = 1'b1;
        end
    end

    // Decision and burst state, advanced only on completed output beats.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            rr_ptr       <= PTR_LAST;
            beat_cnt     <= '0;
        end else if (HREADYM) begin
            addr_in_port <= addr_nxt;
            no_port      <= no_port_nxt;
            rr_ptr       <= rr_ptr_nxt;
            beat_cnt     <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_out_arb_np.sv
// Bench for the N-port output-stage arbiter: one fixed-priority and one
// round-robin instance share the same stimulus; expected grants are
// hand-derived per vector and queued before each clock edge.
module tb_cmsdk_ahb_out_arb_np;
    import cmsdk_ahb_arb_pkg::*;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] f_addr;
    logic       f_np;
    logic [1:0] r_addr;
    logic       r_np;

    int checks = 0;
    int errors = 0;

    // {check_f, f_addr, f_np, check_r, r_addr, r_np}
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic       hsel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic       rdy;
        logic [1:0] fa;
        logic       fnp;
        logic [1:0] ra;
        logic       rnp;
        string      name;
    } vec_t;

    vec_t vecs[8];

    cmsdk_ahb_out_arb_np #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(ARB_FIXED)) u_fixed (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (f_addr),
        .no_port      (f_np)
    );

    cmsdk_ahb_out_arb_np #(.NUM_PORTS(4), .PORT_W(2), .ARB_MODE(ARB_RR)) u_rr (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (r_addr),
        .no_port      (r_np)
    );

    // Clock
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_pop(input string name);
        logic [7:0] e;
        e = exp_q.pop_front();
        if (e[7]) begin
            checks++;
            if ({f_addr, f_np} !== e[6:4]) begin
                errors++;
                $display("FAIL %s fixed: got addr=%0d no_port=%0b want addr=%0d no_port=%0b",
                         name, f_addr, f_np, e[6:5], e[4]);
            end
        end
        if (e[3]) begin
            checks++;
            if ({r_addr, r_np} !== e[2:0]) begin
                errors++;
                $display("FAIL %s rr: got addr=%0d no_port=%0b want addr=%0d no_port=%0b",
                         name, r_addr, r_np, e[2:1], e[0]);
            end
        end
    endtask

    task automatic step(input logic [3:0] req, input logic hsel, input logic [1:0] trans,
                        input logic [2:0] burst, input logic lock, input logic rdy,
                        input logic [1:0] fa, input logic fnp,
                        input logic [1:0] ra, input logic rnp, input string name);
        @(negedge HCLK);
        req_port   = req;
        HSELM      = hsel;
        HTRANSM    = trans;
        HBURSTM    = burst;
        HMASTLOCKM = lock;
        HREADYM    = rdy;
        exp_q.push_back({1'b1, fa, fnp, 1'b1, ra, rnp});
        @(posedge HCLK);
        #1;
        check_pop(name);
    endtask

    task automatic do_reset(input string name);
        @(negedge HCLK);
        HRESETn    = 1'b0;
        req_port   = 4'b0000;
        HSELM      = 1'b0;
        HTRANSM    = HTRANS_IDLE;
        HBURSTM    = HBURST_SINGLE;
        HMASTLOCKM = 1'b0;
        HREADYM    = 1'b1;
        @(posedge HCLK);
        #1;
        exp_q.push_back({1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1});
        check_pop(name);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn    = 1'b0;
        req_port   = 4'b0000;
        HSELM      = 1'b0;
        HTRANSM    = HTRANS_IDLE;
        HBURSTM    = HBURST_SINGLE;
        HMASTLOCKM = 1'b0;
        HREADYM    = 1'b1;

        // req, hsel, trans, burst, lock, rdy, fixed addr/np, rr addr/np
        vecs[0] = '{4'b1010, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, "v0_first_grant"};
        vecs[1] = '{4'b0000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b1, "v1_release"};
        vecs[2] = '{4'b0000, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, "v2_idle_sel"};
        vecs[3] = '{4'b0100, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, "v3_wait_state"};
        vecs[4] = '{4'b0100, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd1, 1'b0, 2'd2, 1'b0, "v4_owner_vs_rr"};
        vecs[5] = '{4'b1000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd3, 1'b0, 2'd3, 1'b0, "v5_port3"};
        vecs[6] = '{4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 2'd3, 1'b0, 2'd3, 1'b0, "v6_locked"};
        vecs[7] = '{4'b0001, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "v7_unlock"};

        do_reset("reset_initial");
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].req, vecs[i].hsel, vecs[i].trans, vecs[i].burst, vecs[i].lock,
                 vecs[i].rdy, vecs[i].fa, vecs[i].fnp, vecs[i].ra, vecs[i].rnp, vecs[i].name);
        end

        // Round-robin rotation with every port requesting
        do_reset("reset_t2");
        step(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t2_g0");
        step(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, "t2_g1");
        step(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, "t2_g2");
        step(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, "t2_g3");
        step(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t2_wrap");

        // INCR8 from port 2 is not broken by a port 0 request
        do_reset("reset_t3");
        step(4'b0100, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_grant2");
        step(4'b0100, 1'b1, HTRANS_NONSEQ, HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_nonseq");
        step(4'b0100, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq1");
        step(4'b0100, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq2");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq3");
        step(4'b0101, 1'b1, HTRANS_BUSY,   HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_busy");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq4");
        step(4'b0001, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b0, 2'd2, 1'b0, 2'd2, 1'b0, "t3_wait");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq5");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq6");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR8,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t3_seq7");
        step(4'b0001, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t3_handover");

        // INCR16 cut short by IDLE; the cleared count lets the next SEQ re-arbitrate
        do_reset("reset_t4");
        step(4'b0100, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t4_grant2");
        step(4'b0100, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t4_nonseq");
        for (int b = 1; b <= 5; b++) begin
            step(4'b0101, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, $sformatf("t4_seq%0d", b));
        end
        step(4'b0001, 1'b1, HTRANS_IDLE,   HBURST_INCR16, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t4_early_term");
        step(4'b0100, 1'b0, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t4_cnt_cleared");

        // Locked transfer across wait states
        do_reset("reset_t5");
        step(4'b0010, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, "t5_grant1");
        step(4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, "t5_wait1");
        step(4'b1000, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, "t5_wait2");
        step(4'b0101, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 1'b0, "t5_wait3");
        step(4'b0001, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, "t5_lock_ready");
        step(4'b0001, 1'b1, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t5_unlock");

        // Idle release, then asynchronous reset in the middle of an INCR4
        step(4'b0000, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1, "t6_no_port");
        step(4'b0100, 1'b0, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t6_grant2");
        step(4'b0100, 1'b1, HTRANS_NONSEQ, HBURST_INCR4,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t6_nonseq");
        step(4'b0101, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 2'd2, 1'b0, 2'd2, 1'b0, "t6_seq1");
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        exp_q.push_back({1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1});
        check_pop("t6_async_reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(4'b0000, 1'b1, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, "t6_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
